// File: rtl/demod_seq_pkg.sv
// Shared types and defaults for the demodulator acquisition-window sequencer.
package demod_seq_pkg;

    localparam int CNT_W_DEF        = 16;
    localparam int DRAIN_CYCLES_DEF = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        ACQUIRE = 2'd2,
        DRAIN   = 2'd3
    } state_t;

endpackage

// File: rtl/demod_seq_counter.sv
// Loadable down-counter that saturates at zero; shared by the settle and window counts.
module demod_seq_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != '0) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/demod_window_sequencer.sv
// Sequences filter settle, acquisition window and pipeline drain for the demodulator.
// Optional macro DEMOD_SEQ_CONTINUOUS_EN adds the continuous re-acquire input.
//
// state   | meaning
// IDLE    | waiting for start, datapath disabled
// SETTLE  | counting settle_len strobes while the filter settles
// ACQUIRE | emitting window samples, one per strobe
// DRAIN   | waiting DRAIN_CYCLES for post-processing to flush
module demod_window_sequencer
    import demod_seq_pkg::*;
#(
    parameter int CNT_W        = CNT_W_DEF,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] settle_len,
    input  logic [CNT_W-1:0] window_len,
    input  logic             sample_strobe,
`ifdef DEMOD_SEQ_CONTINUOUS_EN
    input  logic             continuous,
`endif
    output logic             dp_enable,
    output logic             dp_flush,
    output logic             acq_valid,
    output logic             acq_last,
    output logic [CNT_W-1:0] sample_idx,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] win_q;
    logic [CNT_W-1:0] cnt_q, cnt_val;
    logic             cnt_load, cnt_dec;
    logic [DW-1:0]    drain_q;
    logic             drain_load, win_load;
    logic             flush_d, valid_d, last_d, aborted_d;
    logic [CNT_W-1:0] idx_d;

    // One counter serves both phases: loaded with settle_len, then reloaded with the window.
    demod_seq_counter #(.W(CNT_W)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .count    (cnt_q)
    );

    always_comb begin
        state_d    = state_q;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        cnt_val    = win_q;
        win_load   = 1'b0;
        drain_load = 1'b0;
        flush_d    = 1'b0;
        valid_d    = 1'b0;
        last_d     = 1'b0;
        aborted_d  = 1'b0;
        idx_d      = sample_idx;
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && window_len != '0 && !abort) begin
                    win_load = 1'b1;
                    flush_d  = 1'b1;
                    cnt_load = 1'b1;
                    idx_d    = '0;
                    if (settle_len != '0) begin
                        cnt_val = settle_len;
                        state_d = SETTLE;
                    end else begin
                        cnt_val = window_len;
                        state_d = ACQUIRE;
                    end
                end
            end
            SETTLE: begin
                if (sample_strobe) begin
                    if (cnt_q == ONE) begin
                        cnt_load = 1'b1;
                        state_d  = ACQUIRE;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            ACQUIRE: begin
                if (sample_strobe) begin
                    valid_d = 1'b1;
                    idx_d   = win_q - cnt_q;
                    cnt_dec = 1'b1;
                    if (cnt_q == ONE) begin
                        last_d     = 1'b1;
                        drain_load = 1'b1;
                        state_d    = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drain_q == '0) begin
                    done = 1'b1;
`ifdef DEMOD_SEQ_CONTINUOUS_EN
                    if (continuous) begin
                        cnt_load = 1'b1;
                        state_d  = ACQUIRE;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        // Abort overrides everything, including a done in the final drain cycle.
        if (abort && state_q != IDLE) begin
            state_d    = IDLE;
            aborted_d  = 1'b1;
            done       = 1'b0;
            valid_d    = 1'b0;
            last_d     = 1'b0;
            cnt_load   = 1'b0;
            cnt_dec    = 1'b0;
            drain_load = 1'b0;
            idx_d      = sample_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            win_q      <= '0;
            drain_q    <= '0;
            dp_flush   <= 1'b0;
            acq_valid  <= 1'b0;
            acq_last   <= 1'b0;
            sample_idx <= '0;
            aborted    <= 1'b0;
        end else begin
            state_q    <= state_d;
            dp_flush   <= flush_d;
            acq_valid  <= valid_d;
            acq_last   <= last_d;
            sample_idx <= idx_d;
            aborted    <= aborted_d;
            if (win_load) begin
                win_q <= window_len;
            end
            if (drain_load) begin
                drain_q <= DW'(DRAIN_CYCLES - 1);
            end else if (state_q == DRAIN && drain_q != '0) begin
                drain_q <= drain_q - DW'(1);
            end
        end
    end

    assign dp_enable = (state_q != IDLE);
    assign busy      = dp_enable;

endmodule

// File: tb/tb_demod_window_sequencer.sv
// Randomized bench for demod_window_sequencer against a strobe-schedule reference model.
module tb_demod_window_sequencer;

    localparam int CNT_W = 16;
    localparam int DC    = 4;
    localparam int MAXC  = 256;

    logic             clk = 1'b0;
    logic             reset, start, abort, sample_strobe;
    logic [CNT_W-1:0] settle_len, window_len;
    logic             dp_enable, dp_flush, acq_valid, acq_last, busy, done, aborted;
    logic [CNT_W-1:0] sample_idx;
`ifdef DEMOD_SEQ_CONTINUOUS_EN
    logic             continuous;
`endif

    demod_window_sequencer #(.CNT_W(CNT_W), .DRAIN_CYCLES(DC)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .settle_len    (settle_len),
        .window_len    (window_len),
        .sample_strobe (sample_strobe),
`ifdef DEMOD_SEQ_CONTINUOUS_EN
        .continuous    (continuous),
`endif
        .dp_enable     (dp_enable),
        .dp_flush      (dp_flush),
        .acq_valid     (acq_valid),
        .acq_last      (acq_last),
        .sample_idx    (sample_idx),
        .busy          (busy),
        .done          (done),
        .aborted       (aborted)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected per-cycle outputs of one scenario; cycle 0 is the cycle start is driven.
    bit strb[MAXC];
    bit e_busy[MAXC], e_flush[MAXC], e_valid[MAXC], e_last[MAXC], e_done[MAXC], e_abt[MAXC];
    bit e_ichk[MAXC];
    int e_idx[MAXC];
`ifdef DEMOD_SEQ_CONTINUOUS_EN
    bit cont_drv[MAXC];
`endif
    int run_len, ab, rs;

    function automatic int next_strobe(input int from);
        for (int t = from; t < MAXC - 16; t++) begin
            if (strb[t]) return t;
        end
        return MAXC - 16;
    endfunction

    function automatic int idx1_cycle();
        for (int c = 0; c < MAXC; c++) begin
            if (e_ichk[c] && e_idx[c] == 1) return c;
        end
        return 1;
    endfunction

    // Model: settle consumes the first st strobes after start; each window consumes win strobes
    // seen from ACQUIRE onward; strobes during drain are ignored; done DC-1 cycles after last.
    task automatic build(input int st, input int win, input int nwin, input int ab_mode,
                         input int rs_mode, input bit start_ok, input bit periodic);
        int t, a, fin, acq_start, stop;
        for (int c = 0; c < MAXC; c++) begin
            strb[c]    = periodic ? (c % 4 == 0) : ((c % 5 == 0) || ($urandom_range(2, 0) == 0));
            e_busy[c]  = 0; e_flush[c] = 0; e_valid[c] = 0; e_last[c] = 0;
            e_done[c]  = 0; e_abt[c]   = 0; e_ichk[c]  = 0; e_idx[c]  = 0;
`ifdef DEMOD_SEQ_CONTINUOUS_EN
            cont_drv[c] = 0;
`endif
        end
        ab = -1;
        rs = -1;
        run_len = 8;
        if (!start_ok) return;
        t = 1;
        repeat (st) t = next_strobe(t) + 1;
        acq_start = t;
        fin = t;
        for (int w = 0; w < nwin; w++) begin
            for (int k = 0; k < win; k++) begin
                a = next_strobe(t);
                e_valid[a+1] = 1;
                e_idx[a+1]   = k;
                e_ichk[a+1]  = 1;
                t = a + 1;
            end
            e_last[t]   = 1;
            fin         = t + DC - 1;
            e_done[fin] = 1;
            t = fin + 1;
        end
`ifdef DEMOD_SEQ_CONTINUOUS_EN
        for (int c = 0; c < fin; c++) cont_drv[c] = 1;
`endif
        for (int c = 1; c <= fin; c++) e_busy[c] = 1;
        e_flush[1] = 1;
        case (ab_mode)
            1: ab = idx1_cycle();
            2: ab = fin;
            3: ab = $urandom_range(fin, 1);
            default: ab = -1;
        endcase
        case (rs_mode)
            1: rs = $urandom_range(acq_start - 1, 1);
            2: rs = idx1_cycle();
            default: rs = -1;
        endcase
        stop = fin;
        if (ab >= 0) stop = ab;
        if (rs >= 0) stop = rs;
        for (int c = stop + 1; c < MAXC; c++) begin
            e_busy[c] = 0; e_flush[c] = 0; e_valid[c] = 0; e_last[c] = 0;
            e_done[c] = 0; e_abt[c]   = 0; e_ichk[c]  = 0;
        end
        if (ab >= 0) begin
            e_done[ab]  = 0;
            e_abt[ab+1] = 1;
        end
        if (rs >= 0) begin
            e_ichk[rs+1] = 1;
            e_idx[rs+1]  = 0;
        end
        run_len = stop + 8;
    endtask

    task automatic check_cycle(input string tag, input int c);
        logic [6:0] obs, exp;
        obs = {dp_enable, busy, dp_flush, acq_valid, acq_last, done, aborted};
        exp = {e_busy[c], e_busy[c], e_flush[c], e_valid[c], e_last[c], e_done[c], e_abt[c]};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d flags(en,busy,flush,valid,last,done,abt) got %b expected %b",
                   tag, c, obs, exp);
        end
        if (e_ichk[c]) begin
            checks++;
            assert (sample_idx === CNT_W'(e_idx[c])) else begin
                errors++;
                $error("FAIL %s cycle %0d sample_idx got %0d expected %0d", tag, c, sample_idx, e_idx[c]);
            end
        end
    endtask

    // kind: 0 normal start, 1 start with window_len=0, 2 start together with abort
    task automatic run(input string tag, input int st, input int win, input int kind);
        for (int c = 0; c < run_len; c++) begin
            @(posedge clk);
            #1;
            sample_strobe = strb[c];
            start  = (c == 0) ? 1'b1 : (e_busy[c] && $urandom_range(3, 0) == 0);
            abort  = (c == ab) || (kind == 2 && c == 0) ||
                     (c > 0 && !e_busy[c] && $urandom_range(4, 0) == 0);
            reset  = (c == rs);
            settle_len = (c == 0) ? CNT_W'(st) : CNT_W'($urandom);
            window_len = (c == 0) ? CNT_W'((kind == 1) ? 0 : win) : CNT_W'($urandom);
`ifdef DEMOD_SEQ_CONTINUOUS_EN
            continuous = cont_drv[c];
`endif
            #1;
            check_cycle(tag, c);
        end
        start = 0; abort = 0; reset = 0; sample_strobe = 0;
`ifdef DEMOD_SEQ_CONTINUOUS_EN
        continuous = 0;
`endif
    endtask

    initial begin
        int st, win, am;
        reset = 1; start = 0; abort = 0; sample_strobe = 0;
        settle_len = '0; window_len = '0;
`ifdef DEMOD_SEQ_CONTINUOUS_EN
        continuous = 0;
`endif
        repeat (3) @(posedge clk);
        #1;
        checks++;
        assert ({dp_enable, busy, dp_flush, acq_valid, acq_last, done, aborted} === 7'b0) else begin
            errors++;
            $error("FAIL reset_flags got %b expected 0000000",
                   {dp_enable, busy, dp_flush, acq_valid, acq_last, done, aborted});
        end
        checks++;
        assert (sample_idx === '0) else begin
            errors++;
            $error("FAIL reset_idx got %0d expected 0", sample_idx);
        end
        reset = 0;

        build(3, 5, 1, 0, 0, 1, 1); run("settle3_win5", 3, 5, 0);
        build(0, 1, 1, 0, 0, 1, 0); run("settle0_win1", 0, 1, 0);
        build(2, 4, 1, 1, 0, 1, 0); run("abort_2nd_sample", 2, 4, 0);
        build(0, 0, 1, 0, 0, 0, 0); run("start_win0", 2, 0, 1);
        build(0, 0, 1, 0, 0, 0, 0); run("abort_with_start", 2, 3, 2);
        build(1, 3, 1, 2, 0, 1, 0); run("abort_final_drain", 1, 3, 0);
        build(4, 3, 1, 0, 1, 1, 0); run("reset_mid_settle", 4, 3, 0);
        build(1, 4, 1, 0, 2, 1, 0); run("reset_mid_acquire", 1, 4, 0);
        for (int i = 0; i < 10; i++) begin
            st  = $urandom_range(4, 0);
            win = $urandom_range(6, 1);
            am  = ($urandom_range(1, 0) == 1) ? 3 : 0;
            build(st, win, 1, am, 0, 1, 0);
            run("random", st, win, 0);
        end
`ifdef DEMOD_SEQ_CONTINUOUS_EN
        build(1, 2, 3, 0, 0, 1, 0); run("continuous_win2", 1, 2, 0);
        build(0, 3, 2, 3, 0, 1, 0); run("continuous_abort", 0, 3, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
